// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state encoding
// and the access-size helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    RMW_RD,
    RMW_WR,
    WR_LO,
    WR_HI,
    RESP
  } state_t;

  // Access size in bytes; 0 marks the illegal encoding.
  function automatic logic [3:0] f3_size(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: f3_size = 4'd1;
      F3_H, F3_HU: f3_size = 4'd2;
      F3_W, F3_WU: f3_size = 4'd4;
      F3_D:        f3_size = 4'd8;
      default:     f3_size = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response bus and word-wide data-memory bus of the LSU.
interface lsu_req_if #(parameter int ADDR_W = 64);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic              resp_valid;
  logic [63:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface lsu_mem_if #(parameter int ADDR_W = 64);
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [63:0]       mem_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata
  );
  modport slave (
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata
  );
endinterface

// File: rtl/lsu_load_align.sv
// Picks the byte/half/word at the address offset out of a memory word and
// sign- or zero-extends it to 64 bits according to funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [63:0] data
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    sel_b = word[7:0];
    case (offset)
      2'd1:    sel_b = word[15:8];
      2'd2:    sel_b = word[23:16];
      2'd3:    sel_b = word[31:24];
      default: sel_b = word[7:0];
    endcase
    sel_h = offset[1] ? word[31:16] : word[15:0];

    data = {32'h0, word};
    case (funct3)
      F3_B:    data = {{56{sel_b[7]}}, sel_b};
      F3_H:    data = {{48{sel_h[15]}}, sel_h};
      F3_W:    data = {{32{word[31]}}, word};
      F3_BU:   data = {56'h0, sel_b};
      F3_HU:   data = {48'h0, sel_h};
      default: data = {32'h0, word};
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV64 load/store sequencer onto a 32-bit data memory (1-2 beats, RMW for b/h
// stores). Optional macro LSU_PERF_CNT_EN enables the perf_* counters.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int MEM_BYTES = 512
) (
  input  logic        clk,
  input  logic        reset,
  lsu_req_if.slave    req,
  lsu_mem_if.master   mem,
  output logic [31:0] perf_loads,
  output logic [31:0] perf_stores,
  output logic [31:0] perf_errs
);

  state_t            state_q, state_d;
  logic              write_q, err_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       wdata_q;
  logic [31:0]       lo_q, hi_q;

  logic              accept;
  logic [3:0]        acc_size;
  logic              acc_illegal, acc_misaligned, acc_range, acc_err;

  assign accept = (state_q == IDLE) && req.req_valid;

  always_comb begin
    acc_size       = f3_size(req.req_funct3);
    acc_illegal    = (req.req_funct3 == 3'b111) || (req.req_write && req.req_funct3[2]);
    acc_misaligned = 1'b0;
    case (acc_size)
      4'd2:    acc_misaligned = req.req_addr[0];
      4'd4:    acc_misaligned = |req.req_addr[1:0];
      4'd8:    acc_misaligned = |req.req_addr[2:0];
      default: acc_misaligned = 1'b0;
    endcase
    // One extra bit so addresses near the top of the space cannot wrap.
    acc_range = ({1'b0, req.req_addr} + {{(ADDR_W-3){1'b0}}, acc_size})
                > (ADDR_W+1)'(MEM_BYTES);
    acc_err   = acc_illegal | acc_misaligned | acc_range;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (acc_err)                                               state_d = RESP;
          else if (!req.req_write)                                   state_d = RD_LO;
          else if (req.req_funct3 == F3_W || req.req_funct3 == F3_D) state_d = WR_LO;
          else                                                       state_d = RMW_RD;
        end
      end
      RD_LO:   state_d = (f3_q == F3_D) ? RD_HI : RESP;
      RD_HI:   state_d = RESP;
      RMW_RD:  state_d = RMW_WR;
      RMW_WR:  state_d = RESP;
      WR_LO:   state_d = (f3_q == F3_D) ? WR_HI : RESP;
      WR_HI:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q <= req.req_write;
        err_q   <= acc_err;
        f3_q    <= req.req_funct3;
        addr_q  <= req.req_addr;
        wdata_q <= req.req_wdata;
      end
      if (state_q == RD_LO || state_q == RMW_RD) lo_q <= mem.mem_rdata[31:0];
      if (state_q == RD_HI)                      hi_q <= mem.mem_rdata[31:0];
    end
  end

  logic [ADDR_W-1:0] lo_addr, hi_addr, beat_addr;
  logic [31:0]       merged;
  logic [63:0]       beat_wdata;
  logic              beat_read, beat_write;

  always_comb begin
    lo_addr = {addr_q[ADDR_W-1:2], 2'b00};
    hi_addr = lo_addr + ADDR_W'(4);

    merged = lo_q;
    if (f3_q == F3_B) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0]  = wdata_q[15:0];
    end

    beat_addr  = '0;
    beat_wdata = '0;
    beat_read  = 1'b0;
    beat_write = 1'b0;
    case (state_q)
      RD_LO, RMW_RD: begin beat_addr = lo_addr; beat_read = 1'b1; end
      RD_HI:         begin beat_addr = hi_addr; beat_read = 1'b1; end
      RMW_WR: begin beat_addr = lo_addr; beat_write = 1'b1; beat_wdata = {32'h0, merged};        end
      WR_LO:  begin beat_addr = lo_addr; beat_write = 1'b1; beat_wdata = {32'h0, wdata_q[31:0]};  end
      WR_HI:  begin beat_addr = hi_addr; beat_write = 1'b1; beat_wdata = {32'h0, wdata_q[63:32]}; end
      default: ;
    endcase
  end

  // Gating with reset keeps an aborted sequence from committing on the reset edge.
  assign mem.mem_addr  = beat_addr;
  assign mem.mem_wdata = beat_wdata;
  assign mem.mem_read  = beat_read  & ~reset;
  assign mem.mem_write = beat_write & ~reset;

  logic        unused_rdata_hi;
  assign unused_rdata_hi = ^mem.mem_rdata[63:32];

  logic [63:0] aligned;

  lsu_load_align u_align (
    .word   (lo_q),
    .offset (addr_q[1:0]),
    .funct3 (f3_q),
    .data   (aligned)
  );

  assign req.req_ready  = (state_q == IDLE);
  assign req.resp_valid = (state_q == RESP);
  assign req.resp_err   = (state_q == RESP) && err_q;
  assign req.resp_rdata = ((state_q == RESP) && !err_q && !write_q)
                          ? ((f3_q == F3_D) ? {hi_q, lo_q} : aligned) : 64'h0;

`ifdef LSU_PERF_CNT_EN
  logic [31:0] loads_q, stores_q, errs_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      loads_q  <= '0;
      stores_q <= '0;
      errs_q   <= '0;
    end else if (state_q == RESP) begin
      if (err_q)        errs_q   <= errs_q + 32'd1;
      else if (write_q) stores_q <= stores_q + 32'd1;
      else              loads_q  <= loads_q + 32'd1;
    end
  end

  assign perf_loads  = loads_q;
  assign perf_stores = stores_q;
  assign perf_errs   = errs_q;
`else
  assign perf_loads  = '0;
  assign perf_stores = '0;
  assign perf_errs   = '0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-array reference model, directed
// cases plus randomized traffic, with a word-wide memory model on the mem bus.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int ADDR_W    = 64;
  localparam int MEM_BYTES = 512;

  logic clk = 1'b0;
  logic reset;
  logic fill;
  always #5 clk = ~clk;

  lsu_req_if #(.ADDR_W(ADDR_W)) req_bus ();
  lsu_mem_if #(.ADDR_W(ADDR_W)) mem_bus ();
  logic [31:0] perf_loads, perf_stores, perf_errs;

  load_store_unit #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req_bus),
    .mem         (mem_bus),
    .perf_loads  (perf_loads),
    .perf_stores (perf_stores),
    .perf_errs   (perf_errs)
  );

  // ---------------- data memory model (device on the mem bus) ----------------
  logic [7:0] ram     [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];
  int         rd_idx;

  function automatic logic [7:0] fill_byte(input int i);
    return 8'(i * 7 + 3) ^ 8'(i >> 3);
  endfunction

  assign rd_idx = int'(mem_bus.mem_addr[8:0]);
  assign mem_bus.mem_rdata = (mem_bus.mem_addr <= 64'(MEM_BYTES - 4))
    ? {32'h0, ram[rd_idx+3], ram[rd_idx+2], ram[rd_idx+1], ram[rd_idx]} : 64'h0;

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < MEM_BYTES; i++) ram[i] <= fill_byte(i);
    end else if (mem_bus.mem_write && mem_bus.mem_addr <= 64'(MEM_BYTES - 4)) begin
      for (int i = 0; i < 4; i++) ram[rd_idx+i] <= mem_bus.mem_wdata[8*i +: 8];
    end
  end

  // ---------------- checking infrastructure ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        err;
    logic [63:0] rdata;
    int          lat;
    int          reads;
    int          writes;
    int          cls;      // 0 load, 1 store, 2 error
    int          acc_cyc;
  } exp_t;

  exp_t sb_q[$];

  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd3:       return 8;
      default:    return 4;
    endcase
  endfunction

  // ---------------- monitor ----------------
  int   rd_cnt, wr_cnt;
  int   m_loads, m_stores, m_errs;
  exp_t mon_e;

  always @(negedge clk) begin
    if (reset) begin
      rd_cnt = 0; wr_cnt = 0;
      m_loads = 0; m_stores = 0; m_errs = 0;
    end else begin
      if (mem_bus.mem_read)  rd_cnt++;
      if (mem_bus.mem_write) begin
        wr_cnt++;
        check("mem_wdata_hi_zero", {32'h0, mem_bus.mem_wdata[63:32]}, 64'h0);
      end
      if (req_bus.resp_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_resp", 64'(req_bus.resp_valid), 64'h0);
        end else begin
          mon_e = sb_q.pop_front();
          check("resp_err",   64'(req_bus.resp_err), 64'(mon_e.err));
          check("resp_rdata", req_bus.resp_rdata, mon_e.rdata);
          check("latency",    64'(cyc - mon_e.acc_cyc), 64'(mon_e.lat));
          check("mem_reads",  64'(rd_cnt), 64'(mon_e.reads));
          check("mem_writes", 64'(wr_cnt), 64'(mon_e.writes));
          case (mon_e.cls)
            0:       m_loads++;
            1:       m_stores++;
            default: m_errs++;
          endcase
        end
        rd_cnt = 0; wr_cnt = 0;
      end
    end
  end

  // ---------------- driver + reference model ----------------
  task automatic issue(input logic wr, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wdata);
    exp_t        e;
    int          s, n;
    logic        bad;
    logic [63:0] v;
    s   = size_of(f3);
    bad = (f3 == 3'd7) || (wr && f3[2]) || (addr % s != 0) || (addr > 64'(MEM_BYTES - s));
    e.err = bad; e.rdata = 64'h0; e.reads = 0; e.writes = 0;
    if (bad) begin
      e.lat = 1; e.cls = 2;
    end else if (wr) begin
      for (int i = 0; i < s; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
      e.cls    = 1;
      e.lat    = (s == 4) ? 2 : 3;
      e.reads  = (s < 4) ? 1 : 0;
      e.writes = (s == 8) ? 2 : 1;
    end else begin
      v = 64'h0;
      for (int i = 0; i < s; i++) v[8*i +: 8] = ref_mem[int'(addr) + i];
      if (!f3[2] && s < 8) v = 64'($signed(v << (64 - 8*s)) >>> (64 - 8*s));
      e.rdata = v;
      e.cls   = 0;
      e.lat   = (s == 8) ? 3 : 2;
      e.reads = (s == 8) ? 2 : 1;
    end

    n = 0;
    while (!req_bus.req_ready) begin
      @(negedge clk);
      n++;
      if (n > 50) begin
        check("req_ready_timeout", 64'(req_bus.req_ready), 64'h1);
        return;
      end
    end
    req_bus.req_valid  = 1'b1;
    req_bus.req_write  = wr;
    req_bus.req_funct3 = f3;
    req_bus.req_addr   = addr;
    req_bus.req_wdata  = wdata;
    e.acc_cyc = cyc;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req_bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) check("drain_timeout", 64'(sb_q.size()), 64'h0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_perf(input string tag);
`ifdef LSU_PERF_CNT_EN
    check({tag, "_perf_loads"},  64'(perf_loads),  64'(m_loads));
    check({tag, "_perf_stores"}, 64'(perf_stores), 64'(m_stores));
    check({tag, "_perf_errs"},   64'(perf_errs),   64'(m_errs));
`else
    check({tag, "_perf_loads"},  64'(perf_loads),  64'h0);
    check({tag, "_perf_stores"}, 64'(perf_stores), 64'h0);
    check({tag, "_perf_errs"},   64'(perf_errs),   64'h0);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] raddr;
    logic [2:0]  rf3;
    int          mism;
    logic [63:0] d;

    reset = 1'b1;
    fill  = 1'b1;
    req_bus.req_valid  = 1'b0;
    req_bus.req_write  = 1'b0;
    req_bus.req_funct3 = 3'b0;
    req_bus.req_addr   = '0;
    req_bus.req_wdata  = '0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = fill_byte(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    fill  = 1'b0;
    #1;
    check("rst_req_ready",  64'(req_bus.req_ready),  64'h1);
    check("rst_resp_valid", 64'(req_bus.resp_valid), 64'h0);
    check("rst_resp_rdata", req_bus.resp_rdata,      64'h0);
    check("rst_mem_read",   64'(mem_bus.mem_read),   64'h0);
    check("rst_mem_write",  64'(mem_bus.mem_write),  64'h0);
    check("rst_mem_addr",   mem_bus.mem_addr,        64'h0);
    check_perf("rst");

    // directed cases
    issue(1'b1, F3_D,  64'd256, 64'h1122334455667788);
    issue(1'b0, F3_D,  64'd256, 64'h0);
    issue(1'b1, F3_W,  64'd260, 64'h00000000000000F0);
    issue(1'b0, F3_B,  64'd260, 64'h0);
    issue(1'b0, F3_BU, 64'd260, 64'h0);
    issue(1'b1, F3_W,  64'd264, 64'h00000000AABBCCDD);
    issue(1'b1, F3_B,  64'd266, 64'h0000000000000011);
    issue(1'b0, F3_W,  64'd264, 64'h0);
    issue(1'b0, F3_WU, 64'd264, 64'h0);
    issue(1'b0, F3_H,  64'd257, 64'h0);
    issue(1'b1, F3_D,  64'd260, 64'h0123456789ABCDEF);
    issue(1'b0, F3_W,  64'd510, 64'h0);
    issue(1'b0, 3'b111, 64'd0,  64'h0);
    drain();
    check_perf("directed");

    // reset while the second beat of an sd is on the bus
    d = 64'hCAFEBABE0BADF00D;
    req_bus.req_valid  = 1'b1;
    req_bus.req_write  = 1'b1;
    req_bus.req_funct3 = F3_D;
    req_bus.req_addr   = 64'd256;
    req_bus.req_wdata  = d;
    @(posedge clk);
    @(negedge clk);
    req_bus.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) ref_mem[256 + i] = d[8*i +: 8];
    @(negedge clk);
    #1;
    check("wr_hi_write_active", 64'(mem_bus.mem_write), 64'h1);
    check("wr_hi_addr",         mem_bus.mem_addr,       64'd260);
    reset = 1'b1;
    #1;
    check("reset_gates_write",  64'(mem_bus.mem_write), 64'h0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("post_rst_req_ready",  64'(req_bus.req_ready),  64'h1);
    check("post_rst_resp_valid", 64'(req_bus.resp_valid), 64'h0);
    check("post_rst_mem_write",  64'(mem_bus.mem_write),  64'h0);
    check("word260_unchanged", {32'h0, ram[263], ram[262], ram[261], ram[260]},
          {32'h0, ref_mem[263], ref_mem[262], ref_mem[261], ref_mem[260]});
    check_perf("post_rst");
    issue(1'b0, F3_D, 64'd256, 64'h0);

    // randomized traffic
    for (int t = 0; t < 300; t++) begin
      rf3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        7:       raddr = 64'($urandom_range(0, MEM_BYTES - 1));
        8:       raddr = 64'($urandom_range(500, 511));
        9:       raddr = {$urandom, $urandom};
        default: raddr = 64'($urandom_range(0, MEM_BYTES - 1) & ~(size_of(rf3) - 1));
      endcase
      issue(1'($urandom_range(0, 1)), rf3, raddr, {$urandom, $urandom});
    end
    drain();
    check_perf("final");

    mism = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (ram[i] !== ref_mem[i]) mism++;
    check("mem_image_mismatches", 64'(mism), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
